lsu_mem_if: RTL and testbench

- Load/store unit sitting directly downstream of the control unit.
- Consumes the control unit's memory request: address from ALU result, store data from rs2_data, mem_size, mem_sign and mem_we.
- Drives a word-wide valid/grant data-memory bus and returns the aligned, sign- or zero-extended mem_rdata.
- Runs a request/grant/response FSM and flags misaligned accesses.

---
 rtl/lsu_mem_if.sv | 217 +++++++++++++++++++++
 tb/tb_lsu_mem_if.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns one control-unit memory request into a valid/grant word-bus transaction.
// Optional bus timeout compiled in with `define LSU_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).

package lsu_mem_if_pkg;
  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10
  } mem_size_t;
endpackage

module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  mem_size_t             req_size,
  input  logic                  req_sign,
  input  logic                  req_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  state_t    state, state_next;
  logic [1:0] off_q;
  mem_size_t size_q;
  logic      sign_q;
  logic      we_q;
  logic      err_q, err_next;
  logic      capture;
  logic      misaligned;
  logic      timeout;

  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [3:0]            lane_wstrb;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign bus_req = (state == REQ);
  assign err     = err_q;

  // Unsupported size encodings are folded into the misaligned path.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      MEM_SIZE_B: misaligned = 1'b0;
      MEM_SIZE_H: misaligned = req_addr[0];
      MEM_SIZE_W: misaligned = (req_addr[1:0] != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  end

  always_comb begin
    lane_wdata = req_wdata;
    lane_wstrb = 4'b1111;
    case (req_size)
      MEM_SIZE_B: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_wstrb = 4'b0001 << req_addr[1:0];
      end
      MEM_SIZE_H: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        lane_wdata = req_wdata;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rd_byte  = bus_rdata[7:0];
    rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_ext = bus_rdata;
    case (off_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    case (size_q)
      MEM_SIZE_B: load_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
      MEM_SIZE_H: load_ext = {{16{sign_q & rd_half[15]}}, rd_half};
      default:    load_ext = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // Counter sits at zero in IDLE/DONE, so it starts from zero on every REQ entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == REQ || state == WAIT_R) begin
      wait_cnt <= wait_cnt + 32'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout = (state == REQ || state == WAIT_R) && (wait_cnt == TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // A grant or rvalid in the limit cycle takes priority over the timeout.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = misaligned ? DONE : REQ;
          err_next   = misaligned;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (we_q) begin
            state_next = DONE;
          end else if (bus_rvalid) begin
            state_next = DONE;
            capture    = 1'b1;
          end else begin
            state_next = WAIT_R;
          end
        end else if (timeout) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      WAIT_R: begin
        if (bus_rvalid) begin
          state_next = DONE;
          capture    = 1'b1;
        end else if (timeout) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      off_q     <= '0;
      size_q    <= MEM_SIZE_B;
      sign_q    <= 1'b0;
      we_q      <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_next;
      err_q <= err_next;
      if (state == IDLE && req_valid) begin
        off_q  <= req_addr[1:0];
        size_q <= req_size;
        sign_q <= req_sign;
        we_q   <= req_we;
      end
      if (state == IDLE && state_next == REQ) begin
        bus_we    <= req_we;
        bus_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
        bus_wdata <= lane_wdata;
        bus_wstrb <= lane_wstrb;
      end else if (state_next != REQ) begin
        bus_we    <= 1'b0;
        bus_addr  <= '0;
        bus_wdata <= '0;
        bus_wstrb <= '0;
      end
      if (capture) begin
        mem_rdata <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed vector table, randomized transactions against a
// byte-arithmetic reference model, and hand-written reset / bus-stall sequences.
module tb_lsu_mem_if;
  import lsu_mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_sign, req_we;
  logic [31:0] req_addr, req_wdata;
  mem_size_t   req_size;
  logic        busy, done, err, bus_req, bus_we;
  logic [31:0] mem_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  lsu_mem_if #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign), .req_we(req_we),
    .busy(busy), .done(done), .err(err), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned gnt_dly;
    int unsigned rv_dly;
    logic        inject;
    logic        err;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  strb;
    logic [31:0] rdata_exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int unsigned gd,
                              input int unsigned rd, input logic inj, input logic e,
                              input logic [31:0] baddr, input logic [31:0] bwdata,
                              input logic [3:0] strb, input logic [31:0] rexp);
    vec_t v;
    v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.gnt_dly = gd; v.rv_dly = rd; v.inject = inj; v.err = e;
    v.baddr = baddr; v.bwdata = bwdata; v.strb = strb; v.rdata_exp = rexp;
    return v;
  endfunction

  // Reference: access width in bytes, alignment by modulo, lanes by shift/multiply.
  function automatic vec_t predict(input vec_t v, input logic [31:0] prev);
    vec_t        e = v;
    int unsigned nb;
    int unsigned off;
    logic [31:0] mask, val;
    nb    = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : (v.size == 2'd2) ? 4 : 0;
    off   = v.addr % 4;
    e.err = (nb == 0) || ((v.addr % nb) != 0);
    e.baddr = v.addr - off;
    mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (nb == 1)      e.bwdata = (v.wdata & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) e.bwdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
    else              e.bwdata = v.wdata;
    e.strb = 4'(((32'd1 << nb) - 32'd1) << off);
    val = (v.rdata >> (8 * off)) & mask;
    if (v.sign && nb < 4 && nb > 0 && val[8*nb-1]) val = val | ~mask;
    e.rdata_exp = (!v.we && !e.err) ? val : prev;
    return e;
  endfunction

  task automatic run_txn(input vec_t v);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata;
    req_size = mem_size_t'(v.size); req_sign = v.sign; req_we = v.we;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (v.err) begin
      chk("mis_done", 32'(done), 32'd1);
      chk("mis_err", 32'(err), 32'd1);
      chk("mis_bus_req", 32'(bus_req), 32'd0);
      chk("mis_rdata", mem_rdata, v.rdata_exp);
    end else begin
      for (int unsigned k = 0; k <= v.gnt_dly; k++) begin
        chk("req_bus_req", 32'(bus_req), 32'd1);
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_done", 32'(done), 32'd0);
        chk("bus_addr", bus_addr, v.baddr);
        chk("bus_we", 32'(bus_we), 32'(v.we));
        if (v.we) begin
          chk("bus_wdata", bus_wdata, v.bwdata);
          chk("bus_wstrb", 32'(bus_wstrb), 32'(v.strb));
        end
        bus_gnt = (k == v.gnt_dly);
        if (k < v.gnt_dly) begin
          bus_rvalid = 1'($urandom_range(0, 1));
          bus_rdata  = $urandom;
          req_valid  = v.inject && (k == 0);
          req_addr   = 32'h0000_5000;
        end else begin
          bus_rvalid = !v.we && (v.rv_dly == 0);
          bus_rdata  = v.rdata;
          req_valid  = 1'b0;
        end
        @(posedge clk); #1;
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0; req_valid = 1'b0;
      if (!v.we) begin
        for (int unsigned j = 1; j <= v.rv_dly; j++) begin
          chk("wait_bus_req", 32'(bus_req), 32'd0);
          chk("wait_busy", 32'(busy), 32'd1);
          chk("wait_done", 32'(done), 32'd0);
          bus_rvalid = (j == v.rv_dly);
          bus_rdata  = (j == v.rv_dly) ? v.rdata : $urandom;
          @(posedge clk); #1;
        end
      end
      bus_rvalid = 1'b0;
      chk("done", 32'(done), 32'd1);
      chk("err", 32'(err), 32'd0);
      chk("done_bus_req", 32'(bus_req), 32'd0);
      chk("mem_rdata", mem_rdata, v.rdata_exp);
    end
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_bus_req", 32'(bus_req), 32'd0);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = MEM_SIZE_B;
    req_sign = 1'b0; req_we = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    model_rdata = '0;

    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //            we sz sg addr          wdata          rdata          gd rd inj e  baddr         bwdata         strb     rexp
    tbl[0]  = mk(1, 0, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0,         0, 0, 0, 0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 32'h0);
    tbl[1]  = mk(0, 0, 1, 32'h0000_2001, 32'h0,         32'h0000_80FF, 0, 0, 0, 0, 32'h0000_2000, 32'h0,         4'b0000, 32'hFFFF_FF80);
    tbl[2]  = mk(0, 0, 0, 32'h0000_2001, 32'h0,         32'h0000_80FF, 0, 0, 0, 0, 32'h0000_2000, 32'h0,         4'b0000, 32'h0000_0080);
    tbl[3]  = mk(0, 1, 0, 32'h0000_2002, 32'h0,         32'hBEEF_1234, 2, 3, 1, 0, 32'h0000_2000, 32'h0,         4'b0000, 32'h0000_BEEF);
    tbl[4]  = mk(0, 2, 1, 32'h0000_3002, 32'h0,         32'h0,         0, 0, 0, 1, 32'h0,         32'h0,         4'b0000, 32'h0000_BEEF);
    tbl[5]  = mk(1, 1, 0, 32'h0000_1002, 32'h1234_ABCD, 32'h0,         1, 0, 0, 0, 32'h0000_1000, 32'hABCD_ABCD, 4'b1100, 32'h0000_BEEF);
    tbl[6]  = mk(1, 2, 0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,         0, 0, 0, 0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 32'h0000_BEEF);
    tbl[7]  = mk(0, 1, 1, 32'h0000_2000, 32'h0,         32'h1234_8001, 1, 0, 0, 0, 32'h0000_2000, 32'h0,         4'b0000, 32'hFFFF_8001);
    tbl[8]  = mk(0, 2, 0, 32'h0000_2004, 32'h0,         32'hCAFE_F00D, 1, 2, 0, 0, 32'h0000_2004, 32'h0,         4'b0000, 32'hCAFE_F00D);
    tbl[9]  = mk(0, 3, 0, 32'h0000_2000, 32'h0,         32'h0,         0, 0, 0, 1, 32'h0,         32'h0,         4'b0000, 32'hCAFE_F00D);
    tbl[10] = mk(1, 1, 0, 32'h0000_1001, 32'h0000_FFFF, 32'h0,         0, 0, 0, 1, 32'h0,         32'h0,         4'b0000, 32'hCAFE_F00D);
    tbl[11] = mk(0, 0, 1, 32'h0000_2003, 32'h0,         32'h7F00_0000, 0, 0, 0, 0, 32'h0000_2000, 32'h0,         4'b0000, 32'h0000_007F);

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i]);
      model_rdata = tbl[i].rdata_exp;
    end

    for (int i = 0; i < 80; i++) begin
      int unsigned s;
      rv.we = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 15);
      rv.size = (s == 15) ? 2'd3 : 2'(s % 3);
      rv.sign = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (rv.size == 2'd2) rv.addr[1:0] = 2'b00;
        else if (rv.size == 2'd1) rv.addr[0] = 1'b0;
      end
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.gnt_dly = $urandom_range(0, 3);
      rv.rv_dly = $urandom_range(0, 3);
      rv.inject = 1'($urandom_range(0, 1));
      rv = predict(rv, model_rdata);
      run_txn(rv);
      model_rdata = rv.rdata_exp;
    end

    // Reset while waiting for read data, then a late rvalid must be ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0000_2008; req_size = MEM_SIZE_W; req_we = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; rst = 1'b1;
    chk("rw_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    chk("rr_err", 32'(err), 32'd0);
    chk("rr_bus_req", 32'(bus_req), 32'd0);
    chk("rr_bus_addr", bus_addr, 32'd0);
    chk("rr_bus_wdata", bus_wdata, 32'd0);
    chk("rr_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rr_bus_we", 32'(bus_we), 32'd0);
    chk("rr_mem_rdata", mem_rdata, 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    chk("late_rv_done", 32'(done), 32'd0);
    chk("late_rv_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("late_rv_rdata", mem_rdata, 32'd0);
    model_rdata = '0;
    run_txn(mk(1, 2, 0, 32'h0000_1008, 32'h0BAD_F00D, 32'h0, 0, 0, 0, 0,
               32'h0000_1008, 32'h0BAD_F00D, 4'b1111, 32'h0));

    // Bus never grants.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0000_1010; req_wdata = 32'h5555_AAAA;
    req_size = MEM_SIZE_W; req_we = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      chk("to_bus_req", 32'(bus_req), 32'd1);
      @(posedge clk); #1;
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_bus_req_drop", 32'(bus_req), 32'd0);
    chk("to_rdata", mem_rdata, model_rdata);
    @(posedge clk); #1;
    chk("to_idle", 32'(busy), 32'd0);
`else
    for (int k = 0; k < 1000; k++) begin
      chk("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    chk("stall_bus_req", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk("stall_idle", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
